// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch stage and its queue.
package ifetch_queue_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 6;
    localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Fetch slots usable this cycle: both if two are free, only slot 0 if one is free.
    function automatic logic [1:0] push_slots(input logic [31:0] free_slots);
        if (free_slots >= 32'd2) begin
            return 2'd2;
        end else if (free_slots == 32'd1) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer: up to two pushes and one pop per cycle, synchronous flush.
module inst_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_n,
    input  fetch_entry_t     push0,
    input  fetch_entry_t     push1,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next1;

    assign wr_ptr_next1 = wr_ptr + PTR_W'(1);
    assign head         = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_n != 2'd0) begin
                mem[wr_ptr] <= push0;
            end
            if (push_n == 2'd2) begin
                mem[wr_ptr_next1] <= push1;
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: drives two consecutive imem reads per cycle, buffers them, and feeds decode.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ifetch_queue_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = ifetch_queue_pkg::ADDR_WIDTH,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = ifetch_queue_pkg::RESET_PC
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [ADDR_WIDTH-1:0]              imem_a1,
    output logic [ADDR_WIDTH-1:0]              imem_a2,
    input  logic [DATA_WIDTH-1:0]              imem_rd1,
    input  logic [DATA_WIDTH-1:0]              imem_rd2,
    input  logic                               redirect_valid,
    input  logic [DATA_WIDTH-1:0]              redirect_pc,
    output logic                               inst_valid,
    output logic [DATA_WIDTH-1:0]              inst,
    output logic [DATA_WIDTH-1:0]              inst_pc,
    input  logic                               inst_ready,
    output logic [DATA_WIDTH-1:0]              fetch_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [CNT_W-1:0]      free;
    logic [1:0]            push_n;
    logic                  pop;
    fetch_entry_t          slot0;
    fetch_entry_t          slot1;
    fetch_entry_t          head;
    logic [1:0]            unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign imem_a1  = pc[ADDR_WIDTH+1:2];
    assign imem_a2  = imem_a1 + ADDR_WIDTH'(1);
    assign fetch_pc = pc;

    // Free space is judged before this cycle's pop, so a popped slot is reused next cycle.
    assign free   = CNT_W'(QUEUE_DEPTH) - count;
    assign push_n = redirect_valid ? 2'd0 : push_slots(32'(free));
    assign pop    = inst_valid && inst_ready;

    assign slot0.pc    = pc;
    assign slot0.instr = imem_rd1;
    assign slot1.pc    = pc + DATA_WIDTH'(4);
    assign slot1.instr = imem_rd2;

    always_comb begin
        pc_next = pc + DATA_WIDTH'({push_n, 2'b00});
        if (redirect_valid) begin
            pc_next = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    inst_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_inst_queue (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .push_n (push_n),
        .push0  (slot0),
        .push1  (slot1),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.instr;
    assign inst_pc    = head.pc;

endmodule
